// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending payout controller and the coin-counting
// vending FSM: controller state encoding, coin values, change width and the
// default ack timeout.
// No ports (package).
// -----------------------------------------------------------------------------
package vend_pkg;

  localparam int CHANGE_W        = 6;    // width of change amounts (cents)
  localparam int DIME_CENTS      = 10;   // large payout coin
  localparam int NICKEL_CENTS    = 5;    // small payout coin
  localparam int ACK_TIMEOUT_CYC = 255;  // cycles allowed per ack edge

  typedef enum logic [3:0] {
    IDLE,
    VEND,
    VEND_REL,
    PAY_SEL,
    DIME_REQ,
    NICK_REQ,
    COIN_REL,
    CLEAR,
    WAIT_LOW,
    FAULT
  } state_t;

  // States in which the controller is waiting on an external edge
  // (an ack or the release of Done) and must therefore be supervised.
  function automatic logic is_timed(input state_t s);
    return s inside {VEND, VEND_REL, DIME_REQ, NICK_REQ, COIN_REL, WAIT_LOW};
  endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// -----------------------------------------------------------------------------
// vend_ack_timer
// Cycle counter supervising one wait. Cleared whenever the owning FSM changes
// state, counts while enabled, and flags expiry on the last allowed cycle
// (count == ACK_TIMEOUT-1) so the FSM can divert to its fault state on that
// same edge.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   clr      in  reload the count to zero (state change)
//   en       in  count this cycle (waiting state)
//   expired  out last allowed cycle of the wait reached
// -----------------------------------------------------------------------------
module vend_ack_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    expired = en && (count_q == LAST);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      // Holding at LAST keeps the counter from wrapping if the owner
      // ever lingers; in practice the owner leaves on expiry.
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vend_payout_ctrl.sv
// -----------------------------------------------------------------------------
// vend_payout_ctrl
// Sequences a completed vending transaction: releases the item, pays change
// one coin at a time (dimes first, then a nickel), then pulses ClrMachine to
// reset the vending FSM and waits for Done to fall. Every dispenser exchange
// is a four-phase req/ack handshake supervised by vend_ack_timer; a stalled
// handshake parks the controller in a sticky FAULT state until reset.
// Ports:
//   Clk         in   system clock, rising edge
//   Rst         in   asynchronous active-low reset
//   Done        in   vending FSM reached price (level)
//   ChangeIn    in   change owed, latched when leaving IDLE
//   VendAck     in   item dispenser ack
//   CoinAck     in   coin dispenser ack
//   VendReq     out  item release request
//   DimeReq     out  dispense one dime
//   NickelReq   out  dispense one nickel
//   ClrMachine  out  one-cycle clear pulse to the vending FSM
//   Busy        out  controller not idle
//   Short       out  one-cycle pulse: sub-nickel remainder discarded
//   Fault       out  sticky ack-timeout flag
//   ChangeLeft  out  change still owed
// All outputs are registered and decoded from the next state, so they line up
// exactly with the state register.
// -----------------------------------------------------------------------------
module vend_payout_ctrl
  import vend_pkg::*;
#(
  parameter int CW          = CHANGE_W,
  parameter int DIME        = DIME_CENTS,
  parameter int NICKEL      = NICKEL_CENTS,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_CYC
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Done,
  input  logic [CW-1:0] ChangeIn,
  input  logic          VendAck,
  input  logic          CoinAck,
  output logic          VendReq,
  output logic          DimeReq,
  output logic          NickelReq,
  output logic          ClrMachine,
  output logic          Busy,
  output logic          Short,
  output logic          Fault,
  output logic [CW-1:0] ChangeLeft
);

  localparam logic [CW-1:0] DIME_V   = CW'(DIME);
  localparam logic [CW-1:0] NICKEL_V = CW'(NICKEL);

  state_t        state_q, state_d;
  logic [CW-1:0] change_q, change_d;
  logic          vend_req_q, vend_req_d;
  logic          dime_req_q, dime_req_d;
  logic          nick_req_q, nick_req_d;
  logic          clr_q, clr_d;
  logic          busy_q, busy_d;
  logic          short_q, short_d;
  logic          fault_q, fault_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = is_timed(state_q);

  vend_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk    (Clk),
    .rst_n  (Rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  // Next-state logic. In every waiting state the exit condition is tested
  // before the timeout, so an edge arriving on the last allowed cycle wins.
  always_comb begin
    state_d  = state_q;
    change_d = change_q;
    unique case (state_q)
      IDLE: begin
        if (Done) begin
          state_d  = VEND;
          change_d = ChangeIn;
        end
      end
      VEND: begin
        if (VendAck)          state_d = VEND_REL;
        else if (tmr_expired) state_d = FAULT;
      end
      VEND_REL: begin
        if (!VendAck)         state_d = PAY_SEL;
        else if (tmr_expired) state_d = FAULT;
      end
      PAY_SEL: begin
        if (change_q >= DIME_V)        state_d = DIME_REQ;
        else if (change_q >= NICKEL_V) state_d = NICK_REQ;
        else                           state_d = CLEAR;
      end
      DIME_REQ: begin
        if (CoinAck) begin
          // PAY_SEL guaranteed change_q >= DIME, so no underflow.
          change_d = change_q - DIME_V;
          state_d  = COIN_REL;
        end else if (tmr_expired) begin
          state_d = FAULT;
        end
      end
      NICK_REQ: begin
        if (CoinAck) begin
          change_d = change_q - NICKEL_V;
          state_d  = COIN_REL;
        end else if (tmr_expired) begin
          state_d = FAULT;
        end
      end
      COIN_REL: begin
        if (!CoinAck)         state_d = PAY_SEL;
        else if (tmr_expired) state_d = FAULT;
      end
      CLEAR: begin
        change_d = '0;
        state_d  = WAIT_LOW;
      end
      WAIT_LOW: begin
        // Done is still the old transaction's level; wait for it to drop.
        if (!Done)            state_d = IDLE;
        else if (tmr_expired) state_d = FAULT;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode of the state being entered.
  always_comb begin
    vend_req_d = (state_d == VEND);
    dime_req_d = (state_d == DIME_REQ);
    nick_req_d = (state_d == NICK_REQ);
    clr_d      = (state_d == CLEAR);
    busy_d     = (state_d != IDLE);
    fault_d    = (state_d == FAULT);
    short_d    = (state_q == PAY_SEL) && (state_d == CLEAR) && (change_q != '0);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      change_q   <= '0;
      vend_req_q <= 1'b0;
      dime_req_q <= 1'b0;
      nick_req_q <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      short_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      change_q   <= change_d;
      vend_req_q <= vend_req_d;
      dime_req_q <= dime_req_d;
      nick_req_q <= nick_req_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      short_q    <= short_d;
      fault_q    <= fault_d;
    end
  end

  assign VendReq    = vend_req_q;
  assign DimeReq    = dime_req_q;
  assign NickelReq  = nick_req_q;
  assign ClrMachine = clr_q;
  assign Busy       = busy_q;
  assign Short      = short_q;
  assign Fault      = fault_q;
  assign ChangeLeft = change_q;

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_payout_ctrl
// Self-checking bench for vend_payout_ctrl (ACK_TIMEOUT reduced to 8).
// A delayed-echo dispenser model answers every request; each transaction is
// judged against coin counts derived from the change amount by integer
// division, plus hand sequences for timeout, sticky fault and async reset.
// -----------------------------------------------------------------------------
module tb_vend_payout_ctrl;

  localparam int CW     = 6;
  localparam int DIME   = 10;
  localparam int NICKEL = 5;
  localparam int TMO    = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Done = 1'b0;
  logic [CW-1:0] ChangeIn = '0;
  logic          VendAck = 1'b0;
  logic          CoinAck = 1'b0;
  logic          VendReq, DimeReq, NickelReq, ClrMachine, Busy, Short, Fault;
  logic [CW-1:0] ChangeLeft;

  int tests = 0;
  int fails = 0;

  vend_payout_ctrl #(
    .CW(CW), .DIME(DIME), .NICKEL(NICKEL), .ACK_TIMEOUT(TMO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Done(Done), .ChangeIn(ChangeIn),
    .VendAck(VendAck), .CoinAck(CoinAck),
    .VendReq(VendReq), .DimeReq(DimeReq), .NickelReq(NickelReq),
    .ClrMachine(ClrMachine), .Busy(Busy), .Short(Short), .Fault(Fault),
    .ChangeLeft(ChangeLeft)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b0; Done = 1'b0; VendAck = 1'b0; CoinAck = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
  endtask

  // One complete transaction with a dispenser that echoes each request
  // d cycles later (d >= 1). Expected coin counts come from the caller.
  task automatic run_txn(input int c, input int d, input int ed, input int en, input int es);
    int nd, nn, ns, nc, viol, short_bad, last_coin, clr_cyc, rem;
    bit pd, pn, finished, saw_fault;
    logic [7:0] hv, hc;
    nd = 0; nn = 0; ns = 0; nc = 0; viol = 0; short_bad = 0;
    last_coin = 0; clr_cyc = 0; pd = 0; pn = 0; finished = 0; saw_fault = 0;
    hv = '0; hc = '0;
    @(negedge Clk);
    ChangeIn = CW'(c); Done = 1'b1; VendAck = 1'b0; CoinAck = 1'b0;
    @(negedge Clk);
    check("vend_latency", VendReq, 1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) @(negedge Clk);
      ChangeIn = CW'($urandom);  // must be ignored after the latch
      rem = c - DIME * nd - NICKEL * nn;
      if (DimeReq && !pd) begin
        check("left_at_dime", ChangeLeft, rem);
        check("dime_needed", rem >= DIME, 1);
        nd++; last_coin = cyc;
      end
      if (NickelReq && !pn) begin
        check("left_at_nickel", ChangeLeft, rem);
        check("nickel_needed", (rem >= NICKEL) && (rem < DIME), 1);
        nn++; last_coin = cyc;
      end
      pd = DimeReq; pn = NickelReq;
      if (ClrMachine) begin nc++; clr_cyc = cyc; end
      if (Short) begin ns++; if (!ClrMachine) short_bad++; end
      if (int'(VendReq) + int'(DimeReq) + int'(NickelReq) > 1) viol++;
      if (Fault) begin saw_fault = 1; break; end
      if (nc > 0 && !Busy) begin finished = 1; break; end
      hv = {hv[6:0], VendReq};
      hc = {hc[6:0], DimeReq | NickelReq};
      VendAck = hv[d-1];
      CoinAck = hc[d-1];
      if (nc > 0) Done = 1'b0;
    end
    check("txn_finished", finished, 1);
    check("txn_no_fault", saw_fault, 0);
    check("dime_count", nd, ed);
    check("nickel_count", nn, en);
    check("short_pulses", ns, es);
    check("short_outside_clear", short_bad, 0);
    check("clr_pulses", nc, 1);
    check("req_onehot_viol", viol, 0);
    check("left_after_clear", ChangeLeft, 0);
    if (d == 1 && (ed + en) > 0) check("clr_after_last_coin", clr_cyc - last_coin, 3);
    $display("[TB] txn change=%0d dly=%0d dimes=%0d nickels=%0d short=%0d clr=%0d",
             c, d, nd, nn, ns, nc);
    VendAck = 1'b0; CoinAck = 1'b0; Done = 1'b0;
  endtask

  typedef struct {
    int change;
    int dly;
    int exp_dimes;
    int exp_nickels;
    int exp_short;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int dime_cyc, cnt, vr;
    bit got;

    vecs[0] = '{0,  1, 0, 0, 0};
    vecs[1] = '{20, 1, 2, 0, 0};
    vecs[2] = '{15, 1, 1, 1, 0};
    vecs[3] = '{7,  1, 0, 1, 1};
    vecs[4] = '{4,  2, 0, 0, 1};
    vecs[5] = '{5,  3, 0, 1, 0};
    vecs[6] = '{10, 1, 1, 0, 0};
    vecs[7] = '{63, 4, 6, 0, 1};
    vecs[8] = '{1,  2, 0, 0, 1};
    vecs[9] = '{39, 1, 3, 1, 1};

    // Reset state
    #3;
    check("reset_outputs", {VendReq, DimeReq, NickelReq, ClrMachine, Busy, Short, Fault}, 0);
    check("reset_change_left", ChangeLeft, 0);
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk);
    check("idle_busy", Busy, 0);

    // Table-driven transactions
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].change, vecs[i].dly, vecs[i].exp_dimes,
              vecs[i].exp_nickels, vecs[i].exp_short);
    end

    // Random transactions against the arithmetic coin model
    for (int i = 0; i < 25; i++) begin
      int c, d;
      c = $urandom_range(0, 63);
      d = $urandom_range(1, 4);
      run_txn(c, d, c / DIME, (c % DIME) / NICKEL, ((c % NICKEL) != 0) ? 1 : 0);
    end

    // CoinAck withheld during DIME_REQ: fault after TMO cycles
    do_reset();
    @(negedge Clk);
    ChangeIn = 6'd20; Done = 1'b1;
    dime_cyc = 0; got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (Fault) begin got = 1; break; end
      if (DimeReq) dime_cyc++;
      VendAck = VendReq; CoinAck = 1'b0;
    end
    check("fault_reached", got, 1);
    check("fault_dime_cycles", dime_cyc, TMO);
    check("fault_reqs_low", {VendReq, DimeReq, NickelReq}, 0);
    check("fault_busy", Busy, 1);
    $display("[TB] txn dime timeout: dime cycles=%0d fault=%0d", dime_cyc, Fault);
    VendAck = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      Done = ~Done;
    end
    @(negedge Clk);
    check("fault_sticky", Fault, 1);
    check("fault_sticky_busy", Busy, 1);
    #2 Rst = 1'b0;
    #1;
    check("async_rst_fault", Fault, 0);
    check("async_rst_busy", Busy, 0);
    check("async_rst_left", ChangeLeft, 0);
    @(negedge Clk);
    Done = 1'b0; Rst = 1'b1;

    // Async reset while VendReq is high drops it immediately
    @(negedge Clk);
    ChangeIn = 6'd5; Done = 1'b1;
    @(negedge Clk);
    check("midop_vendreq_up", VendReq, 1);
    #2 Rst = 1'b0;
    #1;
    check("midop_vendreq_drop", VendReq, 0);
    $display("[TB] txn mid-operation reset: VendReq=%0d", VendReq);
    @(negedge Clk);
    Done = 1'b0; Rst = 1'b1;

    // Done held high after ClrMachine: no restart, fault after TMO cycles
    @(negedge Clk);
    ChangeIn = 6'd0; Done = 1'b1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (ClrMachine) begin got = 1; break; end
      VendAck = VendReq; CoinAck = DimeReq | NickelReq;
    end
    check("waitlow_clr_seen", got, 1);
    VendAck = 1'b0; CoinAck = 1'b0;
    cnt = 0; vr = 0; got = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (VendReq) vr++;
      if (Fault) begin cnt = k; got = 1; break; end
    end
    check("waitlow_fault", got, 1);
    check("waitlow_fault_cycle", cnt, TMO + 1);
    check("waitlow_no_vendreq", vr, 0);
    $display("[TB] txn done held high: fault after %0d cycles, vendreqs=%0d", cnt, vr);

    // Fresh transaction after Done has dropped
    do_reset();
    run_txn(25, 1, 2, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vend_payout_ctrl.md
Name: vend_payout_ctrl

Overview:
- Controller that sequences a completed vending transaction: item release, then change payout coin by coin, then clearing the vending FSM for the next customer.
- Sits between the coin-counting vending FSM (which supplies Done and the change amount) and the physical item and coin dispensers.
- Uses four-phase req/ack handshakes with timeout supervision.

Parameters:
- CW, 6, width of change amount (cents).
- DIME, 10, value of large payout coin.
- NICKEL, 5, value of small payout coin.
- ACK_TIMEOUT, 255, max cycles waiting on any ack edge before fault.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Done  in  1  vending FSM reports price reached (level, held until cleared).
- ChangeIn  in  CW  change owed; sampled only on IDLE->VEND.
- VendAck  in  1  item dispenser ack.
- CoinAck  in  1  coin dispenser ack.
- VendReq  out  1  item release request.
- DimeReq  out  1  dispense one DIME.
- NickelReq  out  1  dispense one NICKEL.
- ClrMachine  out  1  one-cycle pulse that resets the vending FSM.
- Busy  out  1  high in any state except IDLE.
- Short  out  1  one-cycle pulse: residual change < NICKEL but nonzero was discarded.
- Fault  out  1  sticky; ack timeout occurred.
- ChangeLeft  out  CW  change still owed (registered).

Behaviour:
- Reset (Rst=0, async): state IDLE; all outputs 0; ChangeLeft=0; timer=0.
- All outputs are registered, with Moore decode from the state.
- States and transitions:
  - IDLE: when Done=1, latch ChangeLeft<=ChangeIn, go VEND.
  - VEND: VendReq=1. When VendAck=1, go VEND_REL.
  - VEND_REL: VendReq=0. When VendAck=0, go PAY_SEL.
  - PAY_SEL (1 cycle):
    - ChangeLeft>=DIME: go DIME_REQ.
    - Else ChangeLeft>=NICKEL: go NICK_REQ.
    - Else: go CLEAR, pulsing Short if ChangeLeft!=0.
  - DIME_REQ / NICK_REQ: corresponding Req=1. When CoinAck=1, subtract the coin value from ChangeLeft (same edge) and go COIN_REL.
  - COIN_REL: Reqs=0. When CoinAck=0, go PAY_SEL.
  - CLEAR: ClrMachine=1 for exactly one cycle; ChangeLeft<=0; go WAIT_LOW.
  - WAIT_LOW: When Done=0, go IDLE. Done still 1 does not restart a transaction.
  - FAULT: all Reqs=0, Fault=1, Busy=1. Only Rst exits this state.
- Handshake rules:
  - A Req never drops before its Ack rises.
  - A new Req is never raised while its Ack is still high.
  - At most one of VendReq/DimeReq/NickelReq is high in any cycle.
- Timeout:
  - The timer clears on every state change and counts while in VEND, VEND_REL, DIME_REQ, NICK_REQ, COIN_REL, or WAIT_LOW.
  - When timer==ACK_TIMEOUT-1 with no exit condition met, go FAULT.
- Arithmetic: subtraction is unsigned CW-bit and is guarded by the PAY_SEL compare, so it never underflows.
- Latency:
  - Done=1 in IDLE gives VendReq=1 on the next cycle.
  - 20-cent change with single-cycle acks: DIME_REQ, COIN_REL, PAY_SEL, DIME_REQ, COIN_REL, PAY_SEL, CLEAR.
- Ignored inputs: ChangeIn changes after latch are ignored. Acks arriving in states that do not expect them are ignored.
- Mid-operation reset: async reset drops every Req immediately. ChangeLeft is lost; no resume is required.

Decomposition:
- Shared package vend_pkg: state enum (IDLE, VEND, VEND_REL, PAY_SEL, DIME_REQ, NICK_REQ, COIN_REL, CLEAR, WAIT_LOW, FAULT), coin value constants, CW.
- The vending FSM reuses the same constants.
- One natural sub-module: vend_ack_timer (load/clear, count, expire at ACK_TIMEOUT-1).

Test Plan:
- Done=1, ChangeIn=0, acks 1 cycle after req:
  - VendReq handshake completes, then no coin reqs.
  - ClrMachine pulses once; Busy drops one cycle after Done=0.
- ChangeIn=20:
  - Exactly two DimeReq handshakes, zero NickelReq.
  - ChangeLeft steps 20→10→0.
  - ClrMachine pulse follows the last COIN_REL.
- ChangeIn=15: DimeReq then NickelReq handshake; ChangeLeft 15→5→0; Short never asserted.
- ChangeIn=7:
  - One NickelReq, leaving ChangeLeft=2.
  - Short pulses one cycle in the cycle CLEAR is entered.
  - ChangeLeft=0 after CLEAR.
- CoinAck held 0 during DIME_REQ with ACK_TIMEOUT=8:
  - Enters FAULT after 8 cycles in DIME_REQ, with all Reqs=0 and Fault=1.
  - FAULT persists with Done toggling; Rst=0 clears everything asynchronously, mid-cycle.
- Done held high after ClrMachine:
  - Stays in WAIT_LOW with no new VendReq; Fault if Done stays high for ACK_TIMEOUT cycles.
  - Re-raising Done after Done=0 starts a fresh transaction.
